soc_system_pio_led: RTL

- Avalon-MM slave output PIO driving the board LED bank; the write-side counterpart of the switch input PIO.
- The HPS lightweight bridge writes, sets or clears output bits, and reads them back.
- An optional hardware blink engine toggles selected bits at a programmable period without CPU involvement.
- Sits on the lightweight HPS-to-FPGA bus beside the switch PIO; out_port goes to the LED pins.

---
 rtl/soc_system_pio_led_pkg.sv | 13 +
 rtl/soc_system_pio_led_blink_timer.sv | 30 +++
 rtl/soc_system_pio_led.sv | 75 +++++++
 3 files changed

// File: rtl/soc_system_pio_led_pkg.sv
// Shared constants for the LED output PIO: register word addresses and blink timer width.
package soc_system_pio_led_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_MASK   = 3'd1;
    localparam logic [2:0] ADDR_PERIOD = 3'd2;
    localparam logic [2:0] ADDR_STATUS = 3'd3;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;

    localparam int unsigned PERIOD_W = 32;

endpackage

// File: rtl/soc_system_pio_led_blink_timer.sv
// Free-running half-period counter producing the blink phase; restart re-arms it from zero.
module soc_system_pio_led_blink_timer
    import soc_system_pio_led_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic [PERIOD_W-1:0] period,
    input  logic                restart,
    output logic                phase
);

    logic [PERIOD_W-1:0] cnt;

    // Restart outranks a terminal-count toggle on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (restart || (period == '0)) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == period - 1'b1) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/soc_system_pio_led.sv
// Avalon-MM output PIO for the LED bank with set/clear aliases and a hardware blink engine.
module soc_system_pio_led
    import soc_system_pio_led_pkg::*;
#(
    parameter int unsigned      WIDTH       = 10,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic [WIDTH-1:0]    data;
    logic [WIDTH-1:0]    blink_mask;
    logic [PERIOD_W-1:0] blink_period;
    logic                phase;
    logic                wr;
    logic                restart;
    logic [31:0]         rd_next;

    assign wr      = chipselect && !write_n;
    assign restart = wr && (address == ADDR_PERIOD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data         <= RESET_VALUE;
            blink_mask   <= '0;
            blink_period <= '0;
        end else if (wr) begin
            case (address)
                ADDR_DATA:   data         <= writedata[WIDTH-1:0];
                ADDR_MASK:   blink_mask   <= writedata[WIDTH-1:0];
                ADDR_PERIOD: blink_period <= writedata[PERIOD_W-1:0];
                ADDR_OUTSET: data         <= data | writedata[WIDTH-1:0];
                ADDR_OUTCLR: data         <= data & ~writedata[WIDTH-1:0];
                default: ;
            endcase
        end
    end

    soc_system_pio_led_blink_timer u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .period  (blink_period),
        .restart (restart),
        .phase   (phase)
    );

    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_DATA, ADDR_OUTSET, ADDR_OUTCLR: rd_next[WIDTH-1:0] = data;
            ADDR_MASK:   rd_next[WIDTH-1:0]    = blink_mask;
            ADDR_PERIOD: rd_next[PERIOD_W-1:0] = blink_period;
            ADDR_STATUS: rd_next[0]            = phase;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_next;
        end
    end

    assign out_port = data ^ (blink_mask & {WIDTH{phase}});

endmodule
